// File: rtl/led_pkg.sv
// Shared LED-chain definitions: channel count and brightness level width,
// common to the pattern generator and the trail/PWM stage.
package led_pkg;
    localparam int LED_N     = 8;
    localparam int LED_PWM_W = 4;

    typedef logic [LED_PWM_W-1:0] led_level_t;
endpackage

// File: rtl/pwm_channel.sv
// One LED channel: brightness level with load/decay, PWM render, and
// a registered pass-through path for bypass mode.
module pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_W = LED_PWM_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set,
    input  logic             decay_tick,
    input  logic [PWM_W-1:0] peak,
    input  logic [PWM_W-1:0] step,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             trail_en,
    input  logic             bypass,
    output logic             led,
    output logic             nonzero
);

    logic [PWM_W-1:0] level;

    // Decay bottoms out at zero instead of wrapping back to full brightness.
    function automatic logic [PWM_W-1:0] sat_sub(input logic [PWM_W-1:0] a,
                                                 input logic [PWM_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level <= '0;
            led   <= 1'b0;
        end else begin
            if (set)
                level <= peak;
            else if (decay_tick)
                level <= sat_sub(level, step);
            // Levels keep evolving in bypass so re-enabling the trail is seamless.
            led <= trail_en ? (level > pwm_cnt) : bypass;
        end
    end

    assign nonzero = |level;

endmodule

// File: rtl/led_trail_pwm.sv
// Comet-trail LED stage: per-channel fading brightness driven by the
// rotating pattern, with shared PWM and decay-tick counters.
module led_trail_pwm
    import led_pkg::*;
#(
    parameter int N_LEDS      = LED_N,
    parameter int PWM_W       = LED_PWM_W,
    parameter int DECAY_DIV_W = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_LEDS-1:0] pattern_in,
    input  logic              trail_en,
    input  logic [PWM_W-1:0]  peak_level,
    input  logic [PWM_W-1:0]  decay_step,
    output logic [N_LEDS-1:0] led_out,
    output logic              any_lit
);

    logic [DECAY_DIV_W-1:0] decay_cnt;
    logic [PWM_W-1:0]       pwm_cnt;
    logic                   decay_tick;
    logic [N_LEDS-1:0]      nonzero;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            decay_cnt <= '0;
            pwm_cnt   <= '0;
            any_lit   <= 1'b0;
        end else begin
            decay_cnt <= decay_cnt + 1'b1;
            pwm_cnt   <= pwm_cnt + 1'b1;
            any_lit   <= |nonzero;
        end
    end

    // First tick lands on the 2^DECAY_DIV_W-th edge after reset release.
    assign decay_tick = &decay_cnt;

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        pwm_channel #(
            .PWM_W(PWM_W)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .set       (pattern_in[i]),
            .decay_tick(decay_tick),
            .peak      (peak_level),
            .step      (decay_step),
            .pwm_cnt   (pwm_cnt),
            .trail_en  (trail_en),
            .bypass    (pattern_in[i]),
            .led       (led_out[i]),
            .nonzero   (nonzero[i])
        );
    end

endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm with a 16-clock decay tick and 4-bit PWM.
module tb_led_trail_pwm;

    logic       clock;
    logic       reset;
    logic [7:0] pattern_in;
    logic       trail_en;
    logic [3:0] peak_level;
    logic [3:0] decay_step;
    logic [7:0] led_out;
    logic       any_lit;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    led_trail_pwm #(
        .N_LEDS(8),
        .PWM_W(4),
        .DECAY_DIV_W(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .pattern_in(pattern_in),
        .trail_en  (trail_en),
        .peak_level(peak_level),
        .decay_step(decay_step),
        .led_out   (led_out),
        .any_lit   (any_lit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; cyc equals decay_cnt since the last reset release.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic to_tick();
        do step(); while (cyc % 16 != 0);
    endtask

    int ones;
    logic [7:0] others;
    logic [3:0] decay_exp [5];

    initial begin
        decay_exp[0] = 4'd11; decay_exp[1] = 4'd7; decay_exp[2] = 4'd3;
        decay_exp[3] = 4'd0;  decay_exp[4] = 4'd0;

        reset = 1'b1; pattern_in = 8'h00; trail_en = 1'b0;
        peak_level = 4'd0; decay_step = 4'd0;
        #12;
        chk("reset_led", led_out, 8'h00);
        chk("reset_any", any_lit, 1'b0);
        chk("reset_lvl0", dut.g_ch[0].u_ch.level, 4'd0);
        reset = 1'b0;
        cyc = 0;

        // Bypass: registered pass-through, one edge
        pattern_in = 8'h81;
        step();
        chk("bypass_81", led_out, 8'h81);
        pattern_in = 8'h00;
        step();
        chk("bypass_00", led_out, 8'h00);
        chk("bypass_any_peak0", any_lit, 1'b0);

        // Duty 12/16 on channel 0
        trail_en = 1'b1; peak_level = 4'd12; decay_step = 4'd0; pattern_in = 8'h01;
        step();
        ones = 0; others = 8'h00;
        for (int k = 0; k < 16; k++) begin
            step();
            ones += int'(led_out[0]);
            others |= {led_out[7:1], 1'b0};
        end
        chk("duty12_count", ones, 12);
        chk("duty12_others", others, 8'h00);
        chk("duty12_any", any_lit, 1'b1);

        // Decay 15 -> 11, 7, 3, 0, 0
        peak_level = 4'd15; decay_step = 4'd4;
        step();
        pattern_in = 8'h00;
        chk("decay_load", dut.g_ch[0].u_ch.level, 4'd15);
        for (int k = 0; k < 5; k++) begin
            to_tick();
            chk($sformatf("decay_lvl%0d", k), dut.g_ch[0].u_ch.level, decay_exp[k]);
            if (k == 3) begin
                chk("decay_any_lag", any_lit, 1'b1);
                step();
                chk("decay_any_off", any_lit, 1'b0);
            end
        end

        // Load vs decay collision on channel 3
        peak_level = 4'd9;
        while (cyc % 16 != 15) step();
        pattern_in = 8'h08;
        step();
        pattern_in = 8'h00;
        chk("collision_lvl3", dut.g_ch[3].u_ch.level, 4'd9);

        // Bypass across a decay tick, then resume trail
        trail_en = 1'b0;
        repeat (17) step();
        chk("toggle_bypass_led", led_out, 8'h00);
        chk("toggle_lvl3", dut.g_ch[3].u_ch.level, 4'd5);
        trail_en = 1'b1; decay_step = 4'd0;
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            ones += int'(led_out[3]);
        end
        chk("toggle_duty5", ones, 5);

        // Asynchronous reset mid-fade
        #2 reset = 1'b1;
        #1;
        chk("midreset_led", led_out, 8'h00);
        chk("midreset_any", any_lit, 1'b0);
        chk("midreset_lvl3", dut.g_ch[3].u_ch.level, 4'd0);
        #2 reset = 1'b0;
        cyc = 0;
        decay_step = 4'd4;
        repeat (20) step();
        chk("post_reset_lvl3", dut.g_ch[3].u_ch.level, 4'd0);
        chk("post_reset_any", any_lit, 1'b0);
        chk("post_reset_led", led_out, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
